// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci utility set (generator and inverse index search).
// Changing the seeds here turns both blocks into a Lucas-sequence variant.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } fib_state_t;

    localparam int FIB_SEED0 = 0;
    localparam int FIB_SEED1 = 1;

endpackage

// File: rtl/fib_index.sv
// Inverse Fibonacci search: walks the sequence one term per cycle to find the
// largest n with F(n) <= value, and flags whether value is itself a term.
module fib_index
    import fib_pkg::*;
#(
    parameter int FIB_WIDTH = 16,
    parameter int IDX_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [FIB_WIDTH-1:0] value,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 exact,
    output logic                 ready,
    output logic                 busy
);

    localparam logic [FIB_WIDTH:0] SEED_A = (FIB_WIDTH+1)'(FIB_SEED0);
    localparam logic [FIB_WIDTH:0] SEED_B = (FIB_WIDTH+1)'(FIB_SEED1);

    fib_state_t           r_state;
    fib_state_t           w_next;
    logic [FIB_WIDTH:0]   r_a;
    logic [FIB_WIDTH:0]   r_b;
    logic [IDX_WIDTH-1:0] r_k;
    logic [FIB_WIDTH-1:0] r_val;
    logic [IDX_WIDTH-1:0] r_idx;
    logic                 r_exact;

    logic                 w_accept;
    logic                 w_stop;
    logic [FIB_WIDTH:0]   w_sum;

    // The extra bit on a/b means the sum of two in-range terms can never wrap;
    // once that bit is set the term is necessarily larger than any operand.
    assign w_accept = start && (r_state != SEARCH);
    assign w_stop   = r_b[FIB_WIDTH] || (r_b[FIB_WIDTH-1:0] > r_val);
    assign w_sum    = r_a + r_b;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: default assignment first so no path through the case can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = SEARCH;
            SEARCH:  if (w_stop)   w_next = DONE;
            DONE:    w_next = w_accept ? SEARCH : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        case (r_state)
            SEARCH:  busy  = 1'b1;
            DONE:    ready = 1'b1;
            default: ;
        endcase
    end

    // Results only change on the stop cycle, so they hold through DONE, IDLE
    // and the whole of any following search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= SEED_A;
            r_b     <= SEED_B;
            r_k     <= '0;
            r_val   <= '0;
            r_idx   <= '0;
            r_exact <= 1'b0;
        end else if (w_accept) begin
            r_a   <= SEED_A;
            r_b   <= SEED_B;
            r_k   <= '0;
            r_val <= value;
        end else if (r_state == SEARCH) begin
            if (w_stop) begin
                r_idx   <= r_k;
                r_exact <= (r_a == {1'b0, r_val});
            end else begin
                r_a <= r_b;
                r_b <= w_sum;
                r_k <= r_k + 1'b1;
            end
        end
    end

    assign idx   = r_idx;
    assign exact = r_exact;

endmodule
